lb_core_credit_arbiter: RTL

Slot-credit scheduler that shares the per-core receive slots between the RX interfaces of the load balancer. Each interface presents a request naming its hash-selected destination core. The block keeps a slot-credit counter per core and grants one request per cycle in round-robin order when the target core is enabled and has a credit. It sits between the per-interface hash FIFOs and the descriptor pop logic of the LB controller, and replaces the ad-hoc single-cycle slot-availability check.

---
 rtl/lb_core_credit_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lb_core_credit_arbiter.sv
// Round-robin slot-credit scheduler: grants RX interface requests to cores that are enabled and hold credits.
// Define LB_CREDIT_RESERVE_EN to compile in the per-core anti-starvation reservation.
module lb_core_credit_arbiter #(
    parameter int IF_COUNT      = 3,
    parameter int CORE_COUNT    = 8,
    parameter int SLOT_COUNT    = 32,
    parameter int SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
    parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
    parameter int IF_WIDTH      = $clog2(IF_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [IF_COUNT-1:0]               req_valid,
    input  logic [IF_COUNT*CORE_ID_WIDTH-1:0] req_core,
    output logic [IF_COUNT-1:0]               req_ready,
    output logic                              grant_valid,
    output logic [IF_WIDTH-1:0]               grant_port,
    output logic [CORE_ID_WIDTH-1:0]          grant_core,
    input  logic [CORE_COUNT-1:0]             core_enable,
    input  logic [CORE_COUNT-1:0]             slot_release,
    input  logic                              credit_init_valid,
    input  logic [CORE_ID_WIDTH-1:0]          credit_init_core,
    input  logic [SLOT_WIDTH-1:0]             credit_init_count,
    input  logic [CORE_ID_WIDTH-1:0]          stat_core,
    output logic [SLOT_WIDTH-1:0]             stat_credit,
    output logic [CORE_COUNT-1:0]             release_err
);
    localparam logic [SLOT_WIDTH-1:0] SLOT_MAX = SLOT_WIDTH'(SLOT_COUNT);
    localparam logic [SLOT_WIDTH-1:0] SLOT_ONE = SLOT_WIDTH'(1);

    logic [CORE_ID_WIDTH-1:0] core_sel    [IF_COUNT];
    logic [SLOT_WIDTH-1:0]    credit_reg  [CORE_COUNT];
    logic [SLOT_WIDTH-1:0]    credit_next [CORE_COUNT];
    logic [CORE_COUNT-1:0]    has_credit;
    logic [CORE_COUNT-1:0]    init_hit;
    logic [CORE_COUNT-1:0]    full;
    logic [CORE_COUNT-1:0]    granted;
    logic [CORE_COUNT-1:0]    err_set;
    logic [SLOT_WIDTH-1:0]    init_value;
    logic [IF_COUNT-1:0]      permit;
    logic [IF_COUNT-1:0]      eligible;
    logic                     win_valid;
    logic [IF_WIDTH-1:0]      win_port;
    logic [CORE_ID_WIDTH-1:0] win_core;
    logic [IF_WIDTH-1:0]      ptr_reg;
    logic [IF_WIDTH-1:0]      ptr_next;
    logic                     grant_valid_reg;
    logic [IF_WIDTH-1:0]      grant_port_reg;
    logic [CORE_ID_WIDTH-1:0] grant_core_reg;
    logic [SLOT_WIDTH-1:0]    stat_credit_reg;
    logic [CORE_COUNT-1:0]    release_err_reg;

    assign init_value = (credit_init_count > SLOT_MAX) ? SLOT_MAX : credit_init_count;

    // A core being re-initialised takes no grant this cycle; reset also blocks any grant.
    generate
        for (genvar gi = 0; gi < IF_COUNT; gi++) begin : g_port
            assign core_sel[gi] = req_core[gi*CORE_ID_WIDTH +: CORE_ID_WIDTH];
            assign eligible[gi] = !rst && req_valid[gi] && core_enable[core_sel[gi]]
                                  && has_credit[core_sel[gi]] && !init_hit[core_sel[gi]]
                                  && permit[gi];
        end
    endgenerate

    always_comb begin
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        win_port  = '0;
        for (int i = 0; i < IF_COUNT; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= IF_COUNT) idx = idx - IF_COUNT;
            if (!win_valid && eligible[idx]) begin
                win_valid = 1'b1;
                win_port  = IF_WIDTH'(idx);
            end
        end
    end

    assign win_core  = core_sel[win_port];
    assign req_ready = win_valid ? (IF_COUNT'(1) << win_port) : '0;
    assign ptr_next  = !win_valid ? ptr_reg :
                       (win_port == IF_WIDTH'(IF_COUNT - 1)) ? '0 : win_port + IF_WIDTH'(1);

    // A grant and a release in the same cycle cancel; a release into a full counter is dropped.
    generate
        for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_core
            assign has_credit[gi]  = credit_reg[gi] != '0;
            assign full[gi]        = credit_reg[gi] == SLOT_MAX;
            assign init_hit[gi]    = credit_init_valid && (credit_init_core == CORE_ID_WIDTH'(gi));
            assign granted[gi]     = win_valid && (win_core == CORE_ID_WIDTH'(gi));
            assign err_set[gi]     = !init_hit[gi] && slot_release[gi] && !granted[gi] && full[gi];
            assign credit_next[gi] = init_hit[gi] ? init_value :
                                     (granted[gi] && !slot_release[gi]) ? credit_reg[gi] - SLOT_ONE :
                                     (!granted[gi] && slot_release[gi] && !full[gi]) ? credit_reg[gi] + SLOT_ONE :
                                     credit_reg[gi];
        end
    endgenerate

`ifdef LB_CREDIT_RESERVE_EN
    logic [CORE_COUNT-1:0] resv_valid_reg;
    logic [CORE_COUNT-1:0] resv_valid_next;
    logic [IF_WIDTH-1:0]   resv_port_reg  [CORE_COUNT];
    logic [IF_WIDTH-1:0]   resv_port_next [CORE_COUNT];

    generate
        for (genvar gi = 0; gi < IF_COUNT; gi++) begin : g_permit
            assign permit[gi] = !resv_valid_reg[core_sel[gi]]
                                || (resv_port_reg[core_sel[gi]] == IF_WIDTH'(gi));
        end
    endgenerate

    // A reservation is taken by the lowest-numbered port starved on an empty, enabled core.
    always_comb begin
        logic [IF_WIDTH-1:0] owner;
        owner           = '0;
        resv_valid_next = resv_valid_reg;
        for (int c = 0; c < CORE_COUNT; c++) resv_port_next[c] = resv_port_reg[c];
        for (int c = 0; c < CORE_COUNT; c++) begin
            owner = resv_port_reg[c];
            if (resv_valid_reg[c]) begin
                if ((granted[c] && win_port == owner) || !req_valid[owner]
                    || core_sel[owner] != CORE_ID_WIDTH'(c) || !core_enable[c] || init_hit[c])
                    resv_valid_next[c] = 1'b0;
            end else if (core_enable[c] && !has_credit[c] && !init_hit[c]) begin
                for (int p = IF_COUNT - 1; p >= 0; p--) begin
                    if (req_valid[p] && core_sel[p] == CORE_ID_WIDTH'(c)) begin
                        resv_valid_next[c] = 1'b1;
                        resv_port_next[c]  = IF_WIDTH'(p);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resv_valid_reg <= '0;
            for (int c = 0; c < CORE_COUNT; c++) resv_port_reg[c] <= '0;
        end else begin
            resv_valid_reg <= resv_valid_next;
            for (int c = 0; c < CORE_COUNT; c++) resv_port_reg[c] <= resv_port_next[c];
        end
    end
`else
    assign permit = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg         <= '0;
            grant_valid_reg <= 1'b0;
            grant_port_reg  <= '0;
            grant_core_reg  <= '0;
            stat_credit_reg <= '0;
            release_err_reg <= '0;
            for (int c = 0; c < CORE_COUNT; c++) credit_reg[c] <= '0;
        end else begin
            ptr_reg         <= ptr_next;
            grant_valid_reg <= win_valid;
            if (win_valid) begin
                grant_port_reg <= win_port;
                grant_core_reg <= win_core;
            end
            stat_credit_reg <= credit_reg[stat_core];
            release_err_reg <= release_err_reg | err_set;
            for (int c = 0; c < CORE_COUNT; c++) credit_reg[c] <= credit_next[c];
        end
    end

    assign grant_valid = grant_valid_reg;
    assign grant_port  = grant_port_reg;
    assign grant_core  = grant_core_reg;
    assign stat_credit = stat_credit_reg;
    assign release_err = release_err_reg;

endmodule
